frame_tx_sched: RTL and testbench

FRAME_TX_SCHED -- requirements
Module: frame_tx_sched

---
 rtl/frame_pkg.sv | 49 ++++
 rtl/row_parity_acc.sv | 35 +++
 rtl/frame_tx_sched.sv | 172 +++++++++++++++++
 tb/tb_frame_tx_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pkg
//  Description : Shared frame geometry, FSM state encodings and the column
//                classifier used by frame_tx_sched and row_parity_acc.
//  Revision    : 1.0  initial release
// ============================================================================
package frame_pkg;

    localparam int ROW_W  = 2;
    localparam int COL_W  = 11;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    // Frame geometry: 4 rows of 16 OH + 1024 payload + 1 parity column
    localparam int              FRAME_ROWS = 4;
    localparam logic [COL_W-1:0] OH_COLS   = 11'd16;
    localparam logic [COL_W-1:0] LAST_COL  = 11'd1040;
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(FRAME_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COL_OH      = 2'd0,
        COL_PAYLOAD = 2'd1,
        COL_PARITY  = 2'd2,
        COL_NONE    = 2'd3
    } col_class_t;

    // Payload spans OH_COLS..LAST_COL-1; anything past LAST_COL is unused
    function automatic col_class_t classify_col(input logic [COL_W-1:0] col);
        if (col < OH_COLS) begin
            return COL_OH;
        end else if (col < LAST_COL) begin
            return COL_PAYLOAD;
        end else if (col == LAST_COL) begin
            return COL_PARITY;
        end else begin
            return COL_NONE;
        end
    endfunction

endpackage : frame_pkg
`default_nettype wire

// File: rtl/row_parity_acc.sv
`default_nettype none
// ============================================================================
//  Module      : row_parity_acc
//  Description : Running XOR of one row's payload bytes. Only compiled when
//                FRAME_TX_PARITY_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef FRAME_TX_PARITY_EN
module row_parity_acc
    import frame_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_accum,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_parity
);

    logic [DATA_W-1:0] r_acc;

    // Clear at the start of each row, fold in every accepted payload byte
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_acc <= '0;
        end else if (i_accum) begin
            r_acc <= r_acc ^ i_data;
        end
    end

    assign o_parity = r_acc;

endmodule : row_parity_acc
`endif
`default_nettype wire

// File: rtl/frame_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tx_sched
//  Description : Frame transmit scheduler. Sequences an external frame
//                position counter, muxes overhead / payload / parity bytes
//                into a registered line stream and keeps status counters.
//                Define FRAME_TX_PARITY_EN to carry a real row parity byte;
//                otherwise the parity column carries 0x00.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_tx_sched
    import frame_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_line_retrans_req,
    input  logic [DATA_W-1:0] i_oh_data,
    output logic              o_oh_rd,
    input  logic [DATA_W-1:0] i_pl_data,
    input  logic              i_pl_valid,
    output logic              o_pl_ready,
    output logic              o_fpc_rst,
    output logic              o_fpc_enable,
    output logic              o_fpc_valid,
    input  logic [ROW_W-1:0]  i_row_cnt,
    input  logic [COL_W-1:0]  i_col_cnt,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    output logic              o_tx_sof,
    output logic              o_tx_eol,
    output logic [CNT_W-1:0]  o_frame_cnt,
    output logic [CNT_W-1:0]  o_underrun_cnt,
    output logic              o_busy
);

    state_t            r_state;
    state_t            w_state_next;
    col_class_t        w_col_class;
    logic              w_run_go;
    logic              w_is_oh;
    logic              w_is_payload;
    logic              w_is_parity;
    logic              w_beat;
    logic              w_underrun;
    logic              w_eof_beat;
    logic              w_row_start;
    logic [DATA_W-1:0] w_beat_data;
    logic [DATA_W-1:0] w_parity;

    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_tx_sof;
    logic              r_tx_eol;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_underrun_cnt;

    // Column decode; a retrans request suppresses every strobe in the same cycle
    assign w_col_class  = classify_col(i_col_cnt);
    assign w_run_go     = (r_state == ST_RUN) && !i_line_retrans_req && !i_rst;
    assign w_is_oh      = w_run_go && (w_col_class == COL_OH);
    assign w_is_payload = w_run_go && (w_col_class == COL_PAYLOAD);
    assign w_is_parity  = w_run_go && (w_col_class == COL_PARITY);
    assign w_beat       = w_is_oh || w_is_parity || (w_is_payload && i_pl_valid);
    assign w_underrun   = w_is_payload && !i_pl_valid;
    assign w_eof_beat   = w_is_parity && (i_row_cnt == LAST_ROW);
    assign w_row_start  = w_is_oh && (i_col_cnt == '0);

    // Counter handshake is purely combinational so the counter never lags
    assign o_oh_rd      = w_is_oh;
    assign o_pl_ready   = w_is_payload;
    assign o_fpc_valid  = w_beat;
    assign o_fpc_enable = w_run_go;
    assign o_fpc_rst    = i_rst || (r_state == ST_SYNC);
    assign o_busy       = (r_state != ST_IDLE);

`ifdef FRAME_TX_PARITY_EN
    row_parity_acc u_row_parity_acc (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_row_start),
        .i_accum  (w_is_payload && i_pl_valid),
        .i_data   (i_pl_data),
        .o_parity (w_parity)
    );
`else
    assign w_parity = '0;
`endif

    // Select the byte carried by this cycle's beat
    always_comb begin
        w_beat_data = '0;
        if (w_is_oh) begin
            w_beat_data = i_oh_data;
        end else if (w_is_payload) begin
            w_beat_data = i_pl_data;
        end else if (w_is_parity) begin
            w_beat_data = w_parity;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: retrans wins over end-of-frame; a dropped enable ends at frame end
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (i_line_retrans_req) begin
                    w_state_next = ST_HOLD;
                end else if (w_eof_beat && !i_enable) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!i_line_retrans_req) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Line stream register stage and status counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_data      <= '0;
            r_tx_valid     <= 1'b0;
            r_tx_sof       <= 1'b0;
            r_tx_eol       <= 1'b0;
            r_frame_cnt    <= '0;
            r_underrun_cnt <= '0;
        end else begin
            r_tx_data  <= w_beat ? w_beat_data : '0;
            r_tx_valid <= w_beat;
            r_tx_sof   <= w_row_start && (i_row_cnt == '0);
            r_tx_eol   <= w_is_parity;
            if (w_eof_beat) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_underrun && (r_underrun_cnt != '1)) begin
                r_underrun_cnt <= r_underrun_cnt + 1'b1;
            end
        end
    end

    assign o_tx_data      = r_tx_data;
    assign o_tx_valid     = r_tx_valid;
    assign o_tx_sof       = r_tx_sof;
    assign o_tx_eol       = r_tx_eol;
    assign o_frame_cnt    = r_frame_cnt;
    assign o_underrun_cnt = r_underrun_cnt;

endmodule : frame_tx_sched
`default_nettype wire

// File: tb/tb_frame_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_tx_sched
//  Description : Self-checking bench for frame_tx_sched with a behavioural
//                frame position counter, a strobe vector table and a
//                byte-stream scoreboard for whole frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        retrans;
    logic [7:0]  oh_data;
    logic        oh_rd;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic        fpc_rst;
    logic        fpc_enable;
    logic        fpc_valid;
    logic [1:0]  row_in;
    logic [10:0] col_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_sof;
    logic        tx_eol;
    logic [15:0] frame_cnt;
    logic [15:0] underrun_cnt;
    logic        busy;

    // Position override lets the vector table jump straight to any column
    logic        ovr = 1'b0;
    logic [1:0]  ovr_row = '0;
    logic [10:0] ovr_col = '0;
    logic [1:0]  m_row = '0;
    logic [10:0] m_col = '0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          beats_seen = 0;
    int          sof_seen = 0;
    int          eol_seen = 0;
    logic        mon_en = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eol;
    } exp_beat_t;

    exp_beat_t exp_q[$];

    typedef struct {
        logic [1:0]  row;
        logic [10:0] col;
        logic        pv;
        logic        rt;
        logic [3:0]  strobes;   // {oh_rd, pl_ready, fpc_valid, fpc_enable}
        logic        tv;
        logic [7:0]  data;
        logic        use_par;
        logic        sof;
        logic        eol;
        int          ui;
        int          fi;
    } vec_t;

    vec_t tbl[14];

    assign oh_data = 8'hF6;
    assign row_in  = ovr ? ovr_row : m_row;
    assign col_in  = ovr ? ovr_col : m_col;
    assign pl_data = col_in[7:0];

    always #5 clk = ~clk;

    frame_tx_sched dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_enable           (enable),
        .i_line_retrans_req (retrans),
        .i_oh_data          (oh_data),
        .o_oh_rd            (oh_rd),
        .i_pl_data          (pl_data),
        .i_pl_valid         (pl_valid),
        .o_pl_ready         (pl_ready),
        .o_fpc_rst          (fpc_rst),
        .o_fpc_enable       (fpc_enable),
        .o_fpc_valid        (fpc_valid),
        .i_row_cnt          (row_in),
        .i_col_cnt          (col_in),
        .o_tx_data          (tx_data),
        .o_tx_valid         (tx_valid),
        .o_tx_sof           (tx_sof),
        .o_tx_eol           (tx_eol),
        .o_frame_cnt        (frame_cnt),
        .o_underrun_cnt     (underrun_cnt),
        .o_busy             (busy)
    );

    // External frame position counter: advance on enable && valid, wrap per row
    always @(posedge clk) begin
        if (fpc_rst) begin
            m_row <= '0;
            m_col <= '0;
        end else if (fpc_enable && fpc_valid) begin
            if (m_col == 11'd1040) begin
                m_col <= '0;
                m_row <= m_row + 2'd1;
            end else begin
                m_col <= m_col + 11'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every line beat is matched against the next expected byte
    always @(negedge clk) begin
        exp_beat_t e;
        if (mon_en && tx_valid) begin
            beats_seen++;
            if (tx_sof) sof_seen++;
            if (tx_eol) eol_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL stream_extra actual=%0h required=none", tx_data);
            end else begin
                e = exp_q.pop_front();
                chk("stream_beat", {22'd0, tx_data, tx_sof, tx_eol}, {22'd0, e.data, e.sof, e.eol});
            end
        end
    end

    task automatic wait_pos(input logic [1:0] r, input logic [10:0] c, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 20000 && !found; k++) begin
            @(negedge clk);
            if (m_row == r && m_col == c) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s actual=timeout required=row%0d_col%0d", name, r, c);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] row, input logic [10:0] col, input logic pv,
                                input logic rt, input logic [3:0] st, input logic tv,
                                input logic [7:0] data, input logic use_par, input logic sof,
                                input logic eol, input int ui, input int fi);
        vec_t v;
        v.row = row; v.col = col; v.pv = pv; v.rt = rt; v.strobes = st; v.tv = tv;
        v.data = data; v.use_par = use_par; v.sof = sof; v.eol = eol; v.ui = ui; v.fi = fi;
        return v;
    endfunction

    initial begin
        logic [7:0]  tb_par;
        logic [7:0]  par;
        logic [7:0]  b;
        logic [15:0] fc0;
        logic [15:0] uc0;
        int          b0;
        bit          found;
        exp_beat_t   eb;

        //               row  col       pv    rt    strobes  tv    data   par   sof   eol  ui fi
        tbl[0]  = mk(2'd0, 11'd0,    1'b1, 1'b0, 4'b1011, 1'b1, 8'hF6, 1'b0, 1'b1, 1'b0, 0, 0);
        tbl[1]  = mk(2'd1, 11'd15,   1'b1, 1'b0, 4'b1011, 1'b1, 8'hF6, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[2]  = mk(2'd0, 11'd16,   1'b1, 1'b0, 4'b0111, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[3]  = mk(2'd2, 11'd1039, 1'b1, 1'b0, 4'b0111, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[4]  = mk(2'd1, 11'd500,  1'b0, 1'b0, 4'b0101, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0);
        tbl[5]  = mk(2'd1, 11'd1040, 1'b0, 1'b0, 4'b0011, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0, 0);
        tbl[6]  = mk(2'd3, 11'd1040, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[7]  = mk(2'd3, 11'd1040, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[8]  = mk(2'd3, 11'd1040, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[9]  = mk(2'd3, 11'd1040, 1'b1, 1'b0, 4'b0011, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1);
        tbl[10] = mk(2'd0, 11'd0,    1'b1, 1'b0, 4'b1011, 1'b1, 8'hF6, 1'b0, 1'b1, 1'b0, 0, 0);
        tbl[11] = mk(2'd0, 11'd700,  1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[12] = mk(2'd0, 11'd700,  1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        tbl[13] = mk(2'd0, 11'd700,  1'b0, 1'b0, 4'b0101, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0);

        rst = 1'b1; enable = 1'b0; retrans = 1'b0; pl_valid = 1'b1;
        tb_par = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("fpc_rst_in_reset", {31'd0, fpc_rst}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_outputs", {22'd0, tx_valid, tx_data, tx_sof, tx_eol},  32'd0);
        chk("reset_strobes", {26'd0, busy, fpc_rst, fpc_enable, fpc_valid, oh_rd, pl_ready}, 32'd0);
        chk("reset_counters", {frame_cnt, underrun_cnt}, 32'd0);

        // ---- strobe / line vector table with forced positions ----
        @(negedge clk);
        ovr = 1'b1; ovr_row = '0; ovr_col = '0; enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ovr_row = tbl[i].row; ovr_col = tbl[i].col;
            pl_valid = tbl[i].pv; retrans = tbl[i].rt;
            #1;
            chk($sformatf("strobes_v%0d", i), {28'd0, oh_rd, pl_ready, fpc_valid, fpc_enable},
                {28'd0, tbl[i].strobes});
            fc0 = frame_cnt; uc0 = underrun_cnt;
            @(posedge clk); #1;
            chk($sformatf("line_v%0d", i), {29'd0, tx_valid, tx_sof, tx_eol},
                {29'd0, tbl[i].tv, tbl[i].sof, tbl[i].eol});
            if (tbl[i].tv)
                chk($sformatf("data_v%0d", i), {24'd0, tx_data},
                    {24'd0, tbl[i].use_par ? tb_par : tbl[i].data});
            chk($sformatf("underrun_v%0d", i), 32'(underrun_cnt - uc0), 32'(tbl[i].ui));
            chk($sformatf("frame_v%0d", i), 32'(frame_cnt - fc0), 32'(tbl[i].fi));
`ifdef FRAME_TX_PARITY_EN
            if (tbl[i].tv && tbl[i].col == 11'd0) tb_par = '0;
            else if (tbl[i].tv && tbl[i].col >= 11'd16 && tbl[i].col < 11'd1040)
                tb_par = tb_par ^ tbl[i].col[7:0];
`endif
        end

        // ---- reset clears counters accumulated by the table ----
        @(negedge clk);
        rst = 1'b1; ovr = 1'b0; enable = 1'b0; retrans = 1'b0; pl_valid = 1'b1;
        @(posedge clk); #1;
        chk("table_reset_counters", {frame_cnt, underrun_cnt}, 32'd0);
        chk("table_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- two full frames through the scoreboard ----
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 4; r++) begin
                par = '0;
                for (int c = 0; c <= 1040; c++) begin
                    if (c < 16) begin
                        eb.data = 8'hF6;
                    end else if (c < 1040) begin
                        b = c[7:0];
`ifdef FRAME_TX_PARITY_EN
                        par = par ^ b;
`endif
                        eb.data = b;
                    end else begin
                        eb.data = par;
                    end
                    eb.sof = (r == 0 && c == 0);
                    eb.eol = (c == 1040);
                    exp_q.push_back(eb);
                end
            end
        end
        mon_en = 1'b1;
        enable = 1'b1;

        found = 1'b0;
        for (int k = 0; k < 6000 && !found; k++) begin
            @(negedge clk); #1;
            if (frame_cnt == 16'd1) found = 1'b1;
        end
        chk("frame1_done", {31'd0, found}, 32'd1);
        chk("frame1_beats", 32'(beats_seen), 32'd4164);
        chk("frame1_sof_eol", {8'd0, 12'(sof_seen), 12'(eol_seen)}, {8'd0, 12'd1, 12'd4});

        // Underrun: payload starves for 10 cycles at col 500
        wait_pos(2'd0, 11'd500, "wait_col500");
        pl_valid = 1'b0;
        #1; b0 = beats_seen;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        chk("underrun_cnt", {16'd0, underrun_cnt}, 32'd10);
        chk("underrun_col_hold", {21'd0, m_col}, 32'd500);
        chk("underrun_no_beats", 32'(beats_seen - b0), 32'd0);
        pl_valid = 1'b1;

        // Stop request mid-frame: the frame must still complete
        wait_pos(2'd1, 11'd0, "wait_row1");
        enable = 1'b0;

        // Retransmit hold at row 2, col 16
        wait_pos(2'd2, 11'd16, "wait_row2_col16");
        retrans = 1'b1;
        #1; b0 = beats_seen;
        chk("hold_strobes", {29'd0, fpc_enable, pl_ready, fpc_valid}, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("hold_position", {19'd0, m_row, m_col}, {19'd0, 2'd2, 11'd16});
        chk("hold_state", {30'd0, busy, fpc_enable}, 32'd2);
        chk("hold_no_beats", 32'(beats_seen - b0), 32'd0);
        retrans = 1'b0;

        found = 1'b0;
        for (int k = 0; k < 6000 && !found; k++) begin
            @(negedge clk); #1;
            if (!busy) found = 1'b1;
        end
        chk("stop_to_idle", {31'd0, found}, 32'd1);
        chk("frame2_cnt", {16'd0, frame_cnt}, 32'd2);
        chk("total_beats", 32'(beats_seen), 32'd8328);
        chk("total_sof_eol", {8'd0, 12'(sof_seen), 12'(eol_seen)}, {8'd0, 12'd2, 12'd8});
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_quiet", {30'd0, busy, tx_valid}, 32'd0);
        mon_en = 1'b0;

        // ---- reset mid-frame at row 1, col 700 ----
        @(negedge clk);
        enable = 1'b1;
        wait_pos(2'd1, 11'd700, "wait_row1_col700");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle", {30'd0, busy, tx_valid}, 32'd0);
        chk("midrst_counters", {frame_cnt, underrun_cnt}, 32'd0);
        chk("midrst_fpc_rst", {31'd0, fpc_rst}, 32'd1);
        @(negedge clk);
        rst = 1'b0; enable = 1'b0;
        #1;
        chk("idle_fpc_rst_low", {31'd0, fpc_rst}, 32'd0);

        // Restart must pass through a single SYNC cycle
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("sync_pulse", {30'd0, fpc_rst, busy}, 32'd3);
        @(posedge clk); #1;
        chk("sync_one_cycle", {30'd0, fpc_rst, tx_valid}, 32'd0);
        @(posedge clk); #1;
        chk("restart_sof", {22'd0, tx_valid, tx_sof, tx_data}, {22'd0, 1'b1, 1'b1, 8'hF6});

        @(negedge clk);
        enable = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_frame_tx_sched
`default_nettype wire
